soc_top_lite: RTL and testbench
===============================

Name: soc_top_lite

Overview:
- Board-level top for the 1C102 bring-up image.
- A UART command engine drives the 8 LEDs and byte exchanges on the SD-card SPI bus.
- JTAG is a 1-bit bypass.
- DDR pins are parked in a safe inactive state.
- Sits directly under the FPGA pin constraints. Everything runs in the sys_clk domain.

Parameters:
- CLK_FREQ, default 0: sys_clk frequency in Hz. 0 selects simulation mode, 16 clocks per UART bit.
- BAUD, default 115200: UART rate. Bit period = CLK_FREQ/BAUD clocks when CLK_FREQ != 0.
- SPI_DIV, default 4: sys_clk cycles per SPI clock half-period.

Ports:
- sys_clk  in  1  system clock
- sys_reset  in  1  async active-high reset
- led  out  8  LED outputs
- RsRx  in  1  UART receive
- RsTx  out  1  UART transmit
- LJTAG_TRST  in  1  JTAG reset, active-low
- LJTAG_TMS  in  1  unused
- LJTAG_TDI  in  1  JTAG data in
- LJTAG_TCK  in  1  JTAG clock, sampled
- LJTAG_RESET  in  1  board reset, active-low, clears bypass
- LJTAG_TDO  out  1  bypass data out
- ddr_dq  inout  32  parked
- ddr_dqs  inout  4  parked
- ddr_dqs_n  inout  4  parked
- ddr_addr  out  15  parked
- ddr_bank  out  3  parked
- ddr_cs  out  1  parked
- ddr_ras  out  1  parked
- ddr_cas  out  1  parked
- ddr_we  out  1  parked
- ddr_ck  out  1  parked
- ddr_ck_n  out  1  parked
- ddr_cke  out  1  parked
- ddr_odt  out  1  parked
- ddr_reset_n  out  1  parked
- ddr_dm  out  4  parked
- sd_miso  in  1  SPI data from card
- sd_clk  out  1  SPI clock
- sd_cs  out  1  SPI chip select, active-low
- sd_mosi  out  1  SPI data to card

Behaviour:
- Reset values:
  - led=0x00, RsTx=1, LJTAG_TDO=0.
  - sd_clk=0, sd_cs=1, sd_mosi=1.
  - All FSMs go to IDLE.
- DDR parking (constant, including during reset):
  - dq/dqs/dqs_n high-Z; addr=0, bank=0, dm=0.
  - cs=ras=cas=we=1; ck=0, ck_n=1.
  - cke=0, odt=0, reset_n=0.
- UART RX, 8N1, LSB first:
  - RsRx passes through a 2-flop synchronizer.
  - Start is detected on a falling edge. Start is re-checked at half a bit; low means valid, high means return to IDLE.
  - Data bits are sampled mid-bit.
  - Stop bit must be 1, else the byte is discarded (framing error).
  - A valid byte sets a 1-cycle rx_valid.
- UART TX, 8N1: idle high, one bit per bit period. tx_busy is asserted from start bit to end of stop bit.
- Command FSM, states IDLE, ARG, EXEC, SPI_WAIT, REPLY:
  - Command byte 0x4C 'L' + data D: led<=D, reply 0x4B.
  - Command byte 0x43 'C' + data D: sd_cs<=D[0], reply 0x4B.
  - Command byte 0x53 'S' + data D: SPI exchange of D, reply with the received byte.
  - Any other command byte: reply 0x3F; no argument is consumed.
- Reply timing: REPLY waits for tx_busy=0, then loads TX; TX start bit begins 1 cycle later.
- RX bytes arriving during EXEC, SPI_WAIT or REPLY are dropped (no queue).
- SPI master, mode 0, MSB first:
  - sd_clk toggles every SPI_DIV cycles, 8 pulses per byte.
  - sd_mosi is set before the first rising edge and changes after each falling edge.
  - sd_miso is sampled on each rising edge.
  - After the byte, sd_clk=0 and sd_mosi=1.
  - sd_cs is not touched by 'S'.
- JTAG bypass:
  - LJTAG_TCK and LJTAG_TDI pass through 2-flop synchronizers.
  - On a detected TCK rising edge: bypass<=TDI.
  - LJTAG_TDO=bypass.
  - LJTAG_TRST=0 or LJTAG_RESET=0 clears bypass asynchronously-sampled, i.e. synchronously in sys_clk.
- Reset mid-operation: any in-flight UART or SPI transfer is aborted and outputs return to reset values immediately.

Optional Feature:
- LED_HEARTBEAT_EN defined: led[7] is bit N of a free-running counter; 'L' writes only led[6:0].
  - N=23 when CLK_FREQ != 0.
  - N=8 when CLK_FREQ=0.
- LED_HEARTBEAT_EN undefined: all 8 LED bits come from the 'L' register; no counter is instantiated.

Test Plan:
- Reset asserted then released (CLK_FREQ=0) -> led=0x00, RsTx=1, sd_cs=1, sd_clk=0, ddr_cke=0, ddr_cs=1, ddr_reset_n=0, ddr_dq=Z.
- UART send 0x4C,0xA5 at 16 clk/bit -> led=0xA5 after the ARG stop bit; RsTx returns frame 0x4B.
- UART send 0x53,0x3C with sd_miso driven by a model returning 0xC3 -> 8 sd_clk pulses with period 8 clocks; mosi bits 0,0,1,1,1,1,0,0; reply byte 0xC3.
- UART send 0x43,0x00 then 0x43,0x01 -> sd_cs goes 0 then 1; two replies 0x4B.
- UART send 0x7A, then a frame with stop bit 0 -> reply 0x3F only; the bad frame gives no reply and no state change.
- JTAG: toggle TCK 10 cycles high/10 low with TDI pattern 1,0,1 -> TDO follows each bit about 3 clocks after the TCK rising edge. Pulse LJTAG_TRST low -> TDO=0.

Source files
------------

// File: rtl/soc_top_lite.sv
// Bring-up top: UART command engine driving LEDs and an SD-card SPI byte exchange, JTAG bypass, DDR parked.
// Optional LED_HEARTBEAT_EN: led[7] becomes a free-running heartbeat bit.
// Command FSM states:
//   state    | meaning
//   IDLE     | waiting for a command byte
//   ARG      | command accepted, waiting for its data byte
//   EXEC     | apply LED/CS write or launch the SPI exchange
//   SPI_WAIT | SPI byte in flight
//   REPLY    | waiting for the transmitter, then send the reply byte
module soc_top_lite #(
  parameter int CLK_FREQ = 0,
  parameter int BAUD     = 115200,
  parameter int SPI_DIV  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_reset,
  output logic [7:0]  led,
  input  logic        RsRx,
  output logic        RsTx,
  input  logic        LJTAG_TRST,
  input  logic        LJTAG_TMS,
  input  logic        LJTAG_TDI,
  input  logic        LJTAG_TCK,
  input  logic        LJTAG_RESET,
  output logic        LJTAG_TDO,
  inout  wire  [31:0] ddr_dq,
  inout  wire  [3:0]  ddr_dqs,
  inout  wire  [3:0]  ddr_dqs_n,
  output logic [14:0] ddr_addr,
  output logic [2:0]  ddr_bank,
  output logic        ddr_cs,
  output logic        ddr_ras,
  output logic        ddr_cas,
  output logic        ddr_we,
  output logic        ddr_ck,
  output logic        ddr_ck_n,
  output logic        ddr_cke,
  output logic        ddr_odt,
  output logic        ddr_reset_n,
  output logic [3:0]  ddr_dm,
  input  logic        sd_miso,
  output logic        sd_clk,
  output logic        sd_cs,
  output logic        sd_mosi
);

  localparam int BIT_CLKS = (CLK_FREQ == 0) ? 16 : CLK_FREQ / BAUD;
  localparam logic [19:0] BIT_M1  = 20'(BIT_CLKS - 1);
  localparam logic [19:0] HALF_M1 = 20'(BIT_CLKS / 2 - 1);
  localparam logic [15:0] SPI_M1  = 16'(SPI_DIV - 1);

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_S = 8'h53;

  // DDR held in a quiet, deselected state regardless of reset
  assign ddr_dq      = 'z;
  assign ddr_dqs     = 'z;
  assign ddr_dqs_n   = 'z;
  assign ddr_addr    = '0;
  assign ddr_bank    = '0;
  assign ddr_dm      = '0;
  assign ddr_cs      = 1'b1;
  assign ddr_ras     = 1'b1;
  assign ddr_cas     = 1'b1;
  assign ddr_we      = 1'b1;
  assign ddr_ck      = 1'b0;
  assign ddr_ck_n    = 1'b1;
  assign ddr_cke     = 1'b0;
  assign ddr_odt     = 1'b0;
  assign ddr_reset_n = 1'b0;

  // ---------------- UART receiver ----------------
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]  rx_state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [19:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh, rx_data;
  logic        rx_valid;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1    <= RsRx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_M1;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            rx_cnt   <= BIT_M1;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt - 20'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= BIT_M1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 20'd1;
          end
        end
        default: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_sh;
            end
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt - 20'd1;
          end
        end
      endcase
    end
  end

  // ---------------- UART transmitter ----------------
  logic        tx_load;
  logic [7:0]  reply_data;
  logic        tx_busy, tx_line;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_bits;
  logic [19:0] tx_cnt;

  assign RsTx = tx_line;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      tx_sh   <= '1;
      tx_bits <= '0;
      tx_cnt  <= '0;
    end else if (!tx_busy) begin
      if (tx_load) begin
        tx_busy <= 1'b1;
        tx_line <= 1'b0;
        tx_sh   <= {1'b1, reply_data};
        tx_bits <= 4'd9;
        tx_cnt  <= BIT_M1;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 20'd1;
    end else if (tx_bits == '0) begin
      tx_busy <= 1'b0;
    end else begin
      tx_line <= tx_sh[0];
      tx_sh   <= {1'b1, tx_sh[8:1]};
      tx_bits <= tx_bits - 4'd1;
      tx_cnt  <= BIT_M1;
    end
  end

  // ---------------- Command FSM ----------------
  localparam logic [2:0] C_IDLE     = 3'd0;
  localparam logic [2:0] C_ARG      = 3'd1;
  localparam logic [2:0] C_EXEC     = 3'd2;
  localparam logic [2:0] C_SPI_WAIT = 3'd3;
  localparam logic [2:0] C_REPLY    = 3'd4;

  logic [2:0] cmd_state;
  logic [7:0] cmd, arg, led_reg;
  logic       cs_reg;
  logic       spi_start, spi_done;
  logic [7:0] spi_rx;

  assign tx_load   = (cmd_state == C_REPLY) && !tx_busy;
  assign spi_start = (cmd_state == C_EXEC) && (cmd == CMD_S);
  assign sd_cs     = cs_reg;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      cmd_state  <= C_IDLE;
      cmd        <= '0;
      arg        <= '0;
      led_reg    <= '0;
      cs_reg     <= 1'b1;
      reply_data <= '0;
    end else begin
      case (cmd_state)
        C_IDLE: begin
          if (rx_valid) begin
            cmd <= rx_data;
            if (rx_data == CMD_L || rx_data == CMD_C || rx_data == CMD_S) begin
              cmd_state <= C_ARG;
            end else begin
              reply_data <= 8'h3F;
              cmd_state  <= C_REPLY;
            end
          end
        end
        C_ARG: begin
          if (rx_valid) begin
            arg       <= rx_data;
            cmd_state <= C_EXEC;
          end
        end
        C_EXEC: begin
          reply_data <= 8'h4B;
          if (cmd == CMD_L) begin
            led_reg   <= arg;
            cmd_state <= C_REPLY;
          end else if (cmd == CMD_C) begin
            cs_reg    <= arg[0];
            cmd_state <= C_REPLY;
          end else begin
            cmd_state <= C_SPI_WAIT;
          end
        end
        C_SPI_WAIT: begin
          if (spi_done) begin
            reply_data <= spi_rx;
            cmd_state  <= C_REPLY;
          end
        end
        default: begin
          if (!tx_busy) cmd_state <= C_IDLE;
        end
      endcase
    end
  end

  // ---------------- SPI master (mode 0, MSB first) ----------------
  logic        spi_busy, sck_r, mosi_r;
  logic [15:0] spi_cnt;
  logic [3:0]  spi_edges;
  logic [7:0]  spi_tx_sh;

  assign sd_clk  = sck_r;
  assign sd_mosi = mosi_r;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      spi_busy  <= 1'b0;
      sck_r     <= 1'b0;
      mosi_r    <= 1'b1;
      spi_cnt   <= '0;
      spi_edges <= '0;
      spi_tx_sh <= '0;
      spi_rx    <= '0;
      spi_done  <= 1'b0;
    end else begin
      spi_done <= 1'b0;
      if (!spi_busy) begin
        if (spi_start) begin
          spi_busy  <= 1'b1;
          mosi_r    <= arg[7];
          spi_tx_sh <= arg;
          spi_cnt   <= SPI_M1;
          spi_edges <= '0;
        end
      end else if (spi_cnt != '0) begin
        spi_cnt <= spi_cnt - 16'd1;
      end else begin
        spi_cnt   <= SPI_M1;
        sck_r     <= ~sck_r;
        spi_edges <= spi_edges + 4'd1;
        if (!sck_r) begin
          spi_rx <= {spi_rx[6:0], sd_miso};
        end else if (spi_edges == 4'd15) begin
          mosi_r   <= 1'b1;
          spi_busy <= 1'b0;
          spi_done <= 1'b1;
        end else begin
          spi_tx_sh <= {spi_tx_sh[6:0], 1'b0};
          mosi_r    <= spi_tx_sh[6];
        end
      end
    end
  end

  // ---------------- JTAG bypass ----------------
  logic tck_s1, tck_s2, tck_prev, tdi_s1, tdi_s2, bypass;

  assign LJTAG_TDO = bypass;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      tck_s1   <= 1'b0;
      tck_s2   <= 1'b0;
      tck_prev <= 1'b0;
      tdi_s1   <= 1'b0;
      tdi_s2   <= 1'b0;
      bypass   <= 1'b0;
    end else begin
      tck_s1   <= LJTAG_TCK;
      tck_s2   <= tck_s1;
      tck_prev <= tck_s2;
      tdi_s1   <= LJTAG_TDI;
      tdi_s2   <= tdi_s1;
      if (!LJTAG_TRST || !LJTAG_RESET) bypass <= 1'b0;
      else if (tck_s2 && !tck_prev)    bypass <= tdi_s2;
    end
  end

  // ---------------- LED output ----------------
`ifdef LED_HEARTBEAT_EN
  localparam int HB_N = (CLK_FREQ == 0) ? 8 : 23;
  logic [HB_N:0] hb_cnt;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) hb_cnt <= '0;
    else           hb_cnt <= hb_cnt + 1'b1;
  end

  assign led = {hb_cnt[HB_N], led_reg[6:0]};
`else
  assign led = led_reg;
`endif

  logic unused_ok;
  assign unused_ok = ^{LJTAG_TMS, led_reg[7]};

endmodule

// File: tb/tb_soc_top_lite.sv
// Directed bench for soc_top_lite in simulation mode: UART commands, SPI slave model, JTAG bypass, reset.
module tb_soc_top_lite;

  logic        sys_clk = 1'b0;
  logic        sys_reset;
  logic [7:0]  led;
  logic        RsRx, RsTx;
  logic        LJTAG_TRST, LJTAG_TMS, LJTAG_TDI, LJTAG_TCK, LJTAG_RESET, LJTAG_TDO;
  wire  [31:0] ddr_dq;
  wire  [3:0]  ddr_dqs, ddr_dqs_n;
  logic [14:0] ddr_addr;
  logic [2:0]  ddr_bank;
  logic        ddr_cs, ddr_ras, ddr_cas, ddr_we, ddr_ck, ddr_ck_n, ddr_cke, ddr_odt, ddr_reset_n;
  logic [3:0]  ddr_dm;
  logic        sd_miso, sd_clk, sd_cs, sd_mosi;

  int n_tests = 0;
  int n_fail  = 0;

  soc_top_lite dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .led(led), .RsRx(RsRx), .RsTx(RsTx),
    .LJTAG_TRST(LJTAG_TRST), .LJTAG_TMS(LJTAG_TMS), .LJTAG_TDI(LJTAG_TDI),
    .LJTAG_TCK(LJTAG_TCK), .LJTAG_RESET(LJTAG_RESET), .LJTAG_TDO(LJTAG_TDO),
    .ddr_dq(ddr_dq), .ddr_dqs(ddr_dqs), .ddr_dqs_n(ddr_dqs_n), .ddr_addr(ddr_addr),
    .ddr_bank(ddr_bank), .ddr_cs(ddr_cs), .ddr_ras(ddr_ras), .ddr_cas(ddr_cas),
    .ddr_we(ddr_we), .ddr_ck(ddr_ck), .ddr_ck_n(ddr_ck_n), .ddr_cke(ddr_cke),
    .ddr_odt(ddr_odt), .ddr_reset_n(ddr_reset_n), .ddr_dm(ddr_dm),
    .sd_miso(sd_miso), .sd_clk(sd_clk), .sd_cs(sd_cs), .sd_mosi(sd_mosi)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic uart_send(input logic [7:0] d, input logic stop);
    RsRx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      RsRx = d[i];
      tick(16);
    end
    RsRx = stop;
    tick(16);
    RsRx = 1'b1;
  endtask

  // returns {stop, data}; 9'h100 on timeout
  task automatic uart_recv(output logic [8:0] d);
    int t = 0;
    while (RsTx !== 1'b0 && t < 3000) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 3000) begin
      d = 9'h100;
    end else begin
      d = '0;
      tick(8);
      for (int i = 0; i < 8; i++) begin
        tick(16);
        d[i] = RsTx;
      end
      tick(16);
      d[8] = RsTx;
    end
  endtask

  task automatic spi_slave(input logic [7:0] mb, output logic [7:0] mo,
                           output int pulses, output int span);
    int t = 0;
    int first = -1;
    int last = 0;
    logic prev = 1'b0;
    logic [7:0] sh = mb;
    pulses = 0;
    mo = '0;
    sd_miso = sh[7];
    while (t < 3000 && !(pulses == 8 && !sd_clk)) begin
      @(negedge sys_clk);
      t++;
      if (sd_clk && !prev) begin
        mo = {mo[6:0], sd_mosi};
        pulses++;
        if (first < 0) first = t;
        last = t;
      end
      if (!sd_clk && prev) begin
        sh = {sh[6:0], 1'b0};
        sd_miso = sh[7];
      end
      prev = sd_clk;
    end
    span = last - first;
  endtask

  task automatic jtag_bit(input logic b, input logic old);
    LJTAG_TDI = b;
    tick(10);
    LJTAG_TCK = 1'b1;
    tick(2);
    check("tdo_before_sync", LJTAG_TDO, old);
    tick(1);
    check("tdo_after_edge", LJTAG_TDO, b);
    tick(7);
    LJTAG_TCK = 1'b0;
  endtask

  logic [8:0] rep;
  logic [7:0] mosi_byte;
  int pulses, span, low_cnt, t;

  initial begin
    RsRx = 1'b1; sd_miso = 1'b1;
    LJTAG_TRST = 1'b1; LJTAG_RESET = 1'b1; LJTAG_TCK = 1'b0; LJTAG_TDI = 1'b0; LJTAG_TMS = 1'b0;
    sys_reset = 1'b1;
    tick(5);
    check("ddr_cke_in_reset", ddr_cke, 0);
    check("ddr_cs_in_reset", ddr_cs, 1);
    sys_reset = 1'b0;
    tick(3);
    check("rst_led", led, 8'h00);
    check("rst_rstx", RsTx, 1);
    check("rst_sd_cs", sd_cs, 1);
    check("rst_sd_clk", sd_clk, 0);
    check("rst_sd_mosi", sd_mosi, 1);
    check("rst_tdo", LJTAG_TDO, 0);
    check("ddr_reset_n", ddr_reset_n, 0);
    check("ddr_ck_pair", {ddr_ck, ddr_ck_n}, 2'b01);
    check("ddr_cmd", {ddr_ras, ddr_cas, ddr_we, ddr_odt}, 4'b1110);
    check("ddr_addr_bank_dm", {ddr_addr, ddr_bank, ddr_dm}, 0);

    // 'L' 0xA5
    uart_send(8'h4C, 1'b1);
    fork
      uart_send(8'hA5, 1'b1);
      uart_recv(rep);
    join
    check("l_reply", rep, 9'h14B);
    check("l_led", led, 8'hA5);

    // 'S' 0x3C with slave returning 0xC3
    uart_send(8'h53, 1'b1);
    fork
      uart_send(8'h3C, 1'b1);
      spi_slave(8'hC3, mosi_byte, pulses, span);
      uart_recv(rep);
    join
    check("s_pulses", pulses, 8);
    check("s_period_span", span, 56);
    check("s_mosi_byte", mosi_byte, 8'h3C);
    check("s_reply", rep, 9'h1C3);
    check("s_clk_idle", sd_clk, 0);
    check("s_mosi_idle", sd_mosi, 1);
    check("s_cs_untouched", sd_cs, 1);

    // 'C' 0x00 then 0x01
    uart_send(8'h43, 1'b1);
    fork
      uart_send(8'h00, 1'b1);
      uart_recv(rep);
    join
    check("c0_reply", rep, 9'h14B);
    check("c0_cs", sd_cs, 0);
    uart_send(8'h43, 1'b1);
    fork
      uart_send(8'h01, 1'b1);
      uart_recv(rep);
    join
    check("c1_reply", rep, 9'h14B);
    check("c1_cs", sd_cs, 1);

    // unknown command, then a framing error
    fork
      uart_send(8'h7A, 1'b1);
      uart_recv(rep);
    join
    check("unk_reply", rep, 9'h13F);
    uart_send(8'h55, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (RsTx == 1'b0) low_cnt++;
    end
    check("bad_frame_no_reply", low_cnt, 0);
    check("bad_frame_led", led, 8'hA5);
    uart_send(8'h4C, 1'b1);
    fork
      uart_send(8'h12, 1'b1);
      uart_recv(rep);
    join
    check("l2_reply", rep, 9'h14B);
    check("l2_led", led, 8'h12);

    // reset in the middle of an SPI exchange
    uart_send(8'h53, 1'b1);
    uart_send(8'h3C, 1'b1);
    t = 0;
    while (sd_clk !== 1'b1 && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    check("mid_spi_running", sd_clk, 1);
    sys_reset = 1'b1;
    #1;
    check("mid_rst_sd_clk", sd_clk, 0);
    check("mid_rst_sd_mosi", sd_mosi, 1);
    check("mid_rst_led", led, 8'h00);
    tick(3);
    sys_reset = 1'b0;
    tick(300);
    check("post_rst_rstx_idle", RsTx, 1);
    check("post_rst_sd_clk", sd_clk, 0);

    // JTAG bypass
    jtag_bit(1'b1, 1'b0);
    jtag_bit(1'b0, 1'b1);
    jtag_bit(1'b1, 1'b0);
    LJTAG_TRST = 1'b0;
    tick(2);
    check("trst_clears", LJTAG_TDO, 0);
    LJTAG_TRST = 1'b1;
    jtag_bit(1'b1, 1'b0);
    LJTAG_RESET = 1'b0;
    tick(2);
    check("board_reset_clears", LJTAG_TDO, 0);
    LJTAG_RESET = 1'b1;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
